// File: rtl/tmds_word_aligner.sv
// TMDS symbol aligner: hunts for control-token runs across the 10 bit offsets and locks onto the symbol boundary.
// Define TMDS_ALIGN_STATS_EN to add the saturating lock_loss_cnt output.
module tmds_word_aligner #(
    parameter int RUN_LEN       = 8,
    parameter int LOCK_RUNS     = 4,
    parameter int SEARCH_CYCLES = 2048,
    parameter int LOSS_CYCLES   = 1048576
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [9:0] raw_in,
    output logic [9:0] word_out,
    output logic [1:0] ctrl_out,
    output logic       is_ctrl,
    output logic       locked,
    output logic [3:0] offset
`ifdef TMDS_ALIGN_STATS_EN
    ,
    output logic [7:0] lock_loss_cnt
`endif
);

    // state  | meaning
    // SEARCH | dwell at current offset waiting for a first token run
    // VERIFY | collecting LOCK_RUNS runs at this offset, gaps bounded by dwell
    // LOCKED | aligned; dropped after LOSS_CYCLES without a completed run
    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    localparam int RUN_W   = $clog2(RUN_LEN + 1);
    localparam int RUNS_W  = $clog2(LOCK_RUNS + 1);
    localparam int DWELL_W = $clog2(SEARCH_CYCLES);
    localparam int LOSS_W  = $clog2(LOSS_CYCLES);

    localparam logic [RUN_W-1:0]   RUN_FULL   = RUN_W'(RUN_LEN);
    localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(RUN_LEN - 1);
    localparam logic [RUNS_W-1:0]  RUNS_LAST  = RUNS_W'(LOCK_RUNS - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SEARCH_CYCLES - 1);
    localparam logic [LOSS_W-1:0]  LOSS_LAST  = LOSS_W'(LOSS_CYCLES - 1);

    state_t              state, state_n;
    logic [9:0]          raw_prev;
    logic [9:0]          cand;
    logic                tok;
    logic [1:0]          cand_ctrl;
    logic                run_done;
    logic                run_clr;
    logic [3:0]          offset_n, offset_inc;
    logic [RUN_W-1:0]    run_cnt, run_cnt_n;
    logic [RUNS_W-1:0]   runs_cnt, runs_n;
    logic [DWELL_W-1:0]  dwell_cnt, dwell_n;
    logic [LOSS_W-1:0]   loss_cnt, loss_n;

    assign cand       = 10'({raw_in, raw_prev} >> offset);
    assign offset_inc = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
    assign run_done   = tok && (run_cnt == RUN_LAST);

    always_comb begin
        tok       = 1'b1;
        cand_ctrl = 2'b00;
        case (cand)
            10'h354: cand_ctrl = 2'b00;
            10'h0AB: cand_ctrl = 2'b01;
            10'h154: cand_ctrl = 2'b10;
            10'h2AB: cand_ctrl = 2'b11;
            default: tok = 1'b0;
        endcase
    end

    always_comb begin
        state_n  = state;
        offset_n = offset;
        dwell_n  = dwell_cnt;
        runs_n   = runs_cnt;
        loss_n   = loss_cnt;
        run_clr  = 1'b0;
        case (state)
            SEARCH: begin
                // a run landing on the expiry cycle takes priority over stepping
                if (run_done) begin
                    state_n = VERIFY;
                    runs_n  = RUNS_W'(1);
                    dwell_n = '0;
                end else if (dwell_cnt == DWELL_LAST) begin
                    offset_n = offset_inc;
                    dwell_n  = '0;
                    run_clr  = 1'b1;
                end else begin
                    dwell_n = dwell_cnt + DWELL_W'(1);
                end
            end
            VERIFY: begin
                if (run_done) begin
                    dwell_n = '0;
                    if (runs_cnt == RUNS_LAST) begin
                        state_n = LOCKED;
                        runs_n  = '0;
                        loss_n  = '0;
                    end else begin
                        runs_n = runs_cnt + RUNS_W'(1);
                    end
                end else if (dwell_cnt == DWELL_LAST) begin
                    state_n  = SEARCH;
                    offset_n = offset_inc;
                    dwell_n  = '0;
                    runs_n   = '0;
                    run_clr  = 1'b1;
                end else begin
                    dwell_n = dwell_cnt + DWELL_W'(1);
                end
            end
            LOCKED: begin
                if (run_done) begin
                    loss_n = '0;
                end else if (loss_cnt == LOSS_LAST) begin
                    state_n = SEARCH;
                    loss_n  = '0;
                    dwell_n = '0;
                    runs_n  = '0;
                    run_clr = 1'b1;
                end else begin
                    loss_n = loss_cnt + LOSS_W'(1);
                end
            end
            default: state_n = SEARCH;
        endcase
    end

    always_comb begin
        run_cnt_n = run_cnt;
        if (run_clr || !tok) begin
            run_cnt_n = '0;
        end else if (run_cnt != RUN_FULL) begin
            run_cnt_n = run_cnt + RUN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= SEARCH;
            offset    <= 4'd0;
            run_cnt   <= '0;
            runs_cnt  <= '0;
            dwell_cnt <= '0;
            loss_cnt  <= '0;
            raw_prev  <= '0;
            word_out  <= '0;
            ctrl_out  <= '0;
            is_ctrl   <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state     <= state_n;
            offset    <= offset_n;
            run_cnt   <= run_cnt_n;
            runs_cnt  <= runs_n;
            dwell_cnt <= dwell_n;
            loss_cnt  <= loss_n;
            raw_prev  <= raw_in;
            word_out  <= cand;
            ctrl_out  <= cand_ctrl;
            is_ctrl   <= tok;
            locked    <= (state_n == LOCKED);
        end
    end

`ifdef TMDS_ALIGN_STATS_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_loss_cnt <= '0;
        end else if (state == LOCKED && state_n == SEARCH && lock_loss_cnt != 8'hFF) begin
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tmds_word_aligner.sv
// Scoreboard bench for tmds_word_aligner: serial symbol streams with programmable bit rotation.
module tb_tmds_word_aligner;

    localparam int LOSS   = 4096;
    localparam int SEARCH = 2048;
    localparam int LINE   = 1600;
    localparam int BLANK  = 160;
    localparam int LOCK_N = LINE * 3 + 8 + 1;
    localparam logic [9:0] DATA = 10'h1F0;
    localparam logic [9:0] TOK0 = 10'h354;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [9:0] raw_in = '0;
    logic [9:0] word_out;
    logic [1:0] ctrl_out;
    logic       is_ctrl;
    logic       locked;
    logic [3:0] offset;
`ifdef TMDS_ALIGN_STATS_EN
    logic [7:0] lock_loss_cnt;
`endif

    int vectors = 0;
    int errors  = 0;
    int n       = 0;
    int rot     = 0;
    logic [9:0] prev_sym = DATA;
    logic [9:0] exp_q[$];

    tmds_word_aligner #(.LOSS_CYCLES(LOSS)) dut (
        .clk(clk),
        .resetn(resetn),
        .raw_in(raw_in),
        .word_out(word_out),
        .ctrl_out(ctrl_out),
        .is_ctrl(is_ctrl),
        .locked(locked),
        .offset(offset)
`ifdef TMDS_ALIGN_STATS_EN
        ,
        .lock_loss_cnt(lock_loss_cnt)
`endif
    );

    always #5 clk = ~clk;

    // raw word whose serial bits lag the symbol stream by d bits
    function automatic logic [9:0] rot_word(input logic [9:0] cur, input logic [9:0] prv, input int d);
        logic [19:0] pair;
        pair = {cur, prv};
        pair = pair >> (10 - d);
        return pair[9:0];
    endfunction

    function automatic logic [12:0] decode(input logic [9:0] s);
        case (s)
            10'h354: return {s, 2'b00, 1'b1};
            10'h0AB: return {s, 2'b01, 1'b1};
            10'h154: return {s, 2'b10, 1'b1};
            10'h2AB: return {s, 2'b11, 1'b1};
            default: return {s, 3'b000};
        endcase
    endfunction

    function automatic logic [9:0] line_sym(input int j, input int start);
        if (j >= start && ((j - start) % LINE) < BLANK) return TOK0;
        return DATA;
    endfunction

    task automatic step(input logic [9:0] sym, output logic [9:0] e, output bit ev);
        raw_in = rot_word(sym, prev_sym, rot);
        prev_sym = sym;
        exp_q.push_back(sym);
        @(posedge clk);
        #1;
        n++;
        ev = (exp_q.size() > 1);
        e = '0;
        if (ev) e = exp_q.pop_front();
    endtask

    task automatic do_reset(input int d);
        resetn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            raw_in = 10'($urandom_range(0, 1023));
            @(posedge clk);
            #1;
        end
        resetn = 1'b1;
        n = 0;
        rot = d;
        prev_sym = DATA;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset(0);
        vectors++;
        if ({word_out, ctrl_out, is_ctrl} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", {word_out, ctrl_out, is_ctrl});
        end
        vectors++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL reset_locked got=%b exp=0", locked);
        end
        vectors++;
        if (offset !== 4'd0) begin
            errors++;
            $display("FAIL reset_offset got=%0d exp=0", offset);
        end
    endtask

    task automatic test_offset0();
        logic [9:0]  e;
        bit          ev;
        logic [9:0]  s;
        logic [12:0] got;
        logic [9:0]  toks [4];
        toks[0] = 10'h354; toks[1] = 10'h0AB; toks[2] = 10'h154; toks[3] = 10'h2AB;
        do_reset(0);
        for (int i = 0; i < 5000; i++) begin
            step(line_sym(i, 0), e, ev);
            if (ev) begin
                vectors++;
                got = {word_out, ctrl_out, is_ctrl};
                if (got !== decode(e)) begin
                    errors++;
                    $display("FAIL offset0_word n=%0d got=%h exp=%h", n, got, decode(e));
                end
            end
            if (n == LOCK_N - 1) begin
                vectors++;
                if (locked !== 1'b0) begin
                    errors++;
                    $display("FAIL offset0_early_lock n=%0d got=%b exp=0", n, locked);
                end
            end
            if (n == LOCK_N) begin
                vectors++;
                if (locked !== 1'b1 || offset !== 4'd0) begin
                    errors++;
                    $display("FAIL offset0_lock n=%0d got locked=%b offset=%0d exp locked=1 offset=0", n, locked, offset);
                end
            end
        end
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 4) s = 10'($urandom_range(0, 1023));
            else s = toks[$urandom_range(0, 3)];
            step(s, e, ev);
            vectors++;
            got = {word_out, ctrl_out, is_ctrl};
            if (got !== decode(e)) begin
                errors++;
                $display("FAIL mixed_tokens n=%0d got=%h exp=%h", n, got, decode(e));
            end
        end
        vectors++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL mixed_locked got=%b exp=1", locked);
        end
    endtask

    task automatic test_hunt();
        logic [9:0]  e;
        bit          ev;
        int          i;
        logic [12:0] got;
        do_reset(7);
        i = 0;
        while (!locked && i < 30000) begin
            step(line_sym(i, 0), e, ev);
            i++;
            if (n % SEARCH == SEARCH / 2 && n < SEARCH * 8) begin
                vectors++;
                if (offset !== 4'(n / SEARCH)) begin
                    errors++;
                    $display("FAIL hunt_step n=%0d got=%0d exp=%0d", n, offset, n / SEARCH);
                end
            end
        end
        vectors++;
        if (locked !== 1'b1 || offset !== 4'd7) begin
            errors++;
            $display("FAIL hunt_lock got locked=%b offset=%0d exp locked=1 offset=7", locked, offset);
        end
        for (int k = 0; k < 1000; k++) begin
            step(line_sym(i, 0), e, ev);
            i++;
            vectors++;
            got = {word_out, ctrl_out, is_ctrl};
            if (got !== decode(e)) begin
                errors++;
                $display("FAIL hunt_word n=%0d got=%h exp=%h", n, got, decode(e));
            end
        end
        resetn = 1'b0;
        raw_in = 10'($urandom_range(0, 1023));
        @(posedge clk);
        #1;
        vectors++;
        if ({word_out, ctrl_out, is_ctrl, locked, offset} !== 18'd0) begin
            errors++;
            $display("FAIL mid_reset got=%h exp=0", {word_out, ctrl_out, is_ctrl, locked, offset});
        end
        resetn = 1'b1;
    endtask

    task automatic test_wrap();
        logic [9:0]  e;
        bit          ev;
        int          i;
        logic [12:0] got;
        do_reset(3);
        i = 0;
        while (!locked && i < 40000) begin
            step(line_sym(i, 8192), e, ev);
            i++;
            if (n % SEARCH == SEARCH / 2 && n < SEARCH * 13) begin
                vectors++;
                if (offset !== 4'((n / SEARCH) % 10)) begin
                    errors++;
                    $display("FAIL wrap_step n=%0d got=%0d exp=%0d", n, offset, (n / SEARCH) % 10);
                end
            end
        end
        vectors++;
        if (locked !== 1'b1 || offset !== 4'd3) begin
            errors++;
            $display("FAIL wrap_lock got locked=%b offset=%0d exp locked=1 offset=3", locked, offset);
        end
        for (int k = 0; k < 200; k++) begin
            step(line_sym(i, 8192), e, ev);
            i++;
            vectors++;
            got = {word_out, ctrl_out, is_ctrl};
            if (got !== decode(e)) begin
                errors++;
                $display("FAIL wrap_word n=%0d got=%h exp=%h", n, got, decode(e));
            end
        end
    endtask

    task automatic test_false_run();
        logic [9:0] e;
        bit         ev;
        do_reset(0);
        for (int i = 0; i < 2200; i++) begin
            step((i >= 20 && i < 28) ? TOK0 : DATA, e, ev);
            if (n == 2076 || n == 2077) begin
                vectors++;
                if (offset !== ((n == 2076) ? 4'd0 : 4'd1) || locked !== 1'b0) begin
                    errors++;
                    $display("FAIL false_run n=%0d got offset=%0d locked=%b exp offset=%0d locked=0",
                             n, offset, locked, (n == 2076) ? 0 : 1);
                end
            end
        end
    endtask

    task automatic test_coincide();
        logic [9:0] e;
        bit         ev;
        do_reset(0);
        for (int i = 0; i < 5048; i++) begin
            step((i >= 2039 && i < 6039 && ((i - 2039) % 1000) < 8) ? TOK0 : DATA, e, ev);
            if (n == 2048 || n == 2049) begin
                vectors++;
                if (offset !== 4'd0) begin
                    errors++;
                    $display("FAIL coincide_offset n=%0d got=%0d exp=0", n, offset);
                end
            end
            if (n == 5047 || n == 5048) begin
                vectors++;
                if (locked !== (n == 5048)) begin
                    errors++;
                    $display("FAIL coincide_lock n=%0d got=%b exp=%0d", n, locked, n == 5048);
                end
            end
        end
    endtask

    // continues from the lock reached at the end of test_coincide
    task automatic test_loss();
        logic [9:0] e;
        bit         ev;
        int         m;
        m = 0;
        while (locked && m < LOSS + 100) begin
            step(DATA, e, ev);
            m++;
        end
        vectors++;
        if (m !== LOSS || locked !== 1'b0) begin
            errors++;
            $display("FAIL loss_time got=%0d cycles locked=%b exp=%0d cycles locked=0", m, locked, LOSS);
        end
        vectors++;
        if (offset !== 4'd0) begin
            errors++;
            $display("FAIL loss_offset got=%0d exp=0", offset);
        end
`ifdef TMDS_ALIGN_STATS_EN
        vectors++;
        if (lock_loss_cnt !== 8'd1) begin
            errors++;
            $display("FAIL loss_stats got=%0d exp=1", lock_loss_cnt);
        end
`endif
        for (int k = 1; k <= SEARCH; k++) begin
            step(DATA, e, ev);
            if (k >= SEARCH - 1) begin
                vectors++;
                if (offset !== ((k == SEARCH) ? 4'd1 : 4'd0)) begin
                    errors++;
                    $display("FAIL loss_research k=%0d got=%0d exp=%0d", k, offset, (k == SEARCH) ? 1 : 0);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_offset0();
        test_hunt();
        test_wrap();
        test_false_run();
        test_coincide();
        test_loss();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
